// File: rtl/key_pkg.sv
// Shared definitions for the key buffer load scheduler: word layout, FSM encoding, limits.
// Optional stall timeout is enabled with KEY_LOAD_SCHED_TIMEOUT_EN (see key_load_sched).
package key_pkg;

  localparam int LASTKEY  = 13;
  localparam int FIRST    = 12;
  localparam int LAST     = 11;
  localparam int BEGINGAP = 10;
  localparam int ENDGAP   = 9;
  localparam int MASK     = 8;

  localparam int KEY_W       = 14;
  localparam int GID_W       = 3;
  localparam int MAX_KEY_LEN = 511;
  localparam int STALL_W     = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_ARM  = 2'd2;

  typedef struct packed {
    logic       lastkey;
    logic       first;
    logic       last;
    logic       begingap;
    logic       endgap;
    logic       mask;
    logic [7:0] data;
  } key_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  // Walk from the farthest position back so the nearest request wins last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (i_req[j]) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/key_load_sched.sv
// Round-robin key loader into the key buffer, arming a replay start after a full key set.
// Define KEY_LOAD_SCHED_TIMEOUT_EN to add a stall timeout and the timeout_err port.
module key_load_sched
  import key_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [6*NUM_REQ-1:0] req_flags,
  input  logic [2*NUM_REQ-1:0] req_bytemode,
  output logic [1:0]           byte_mode,
  output logic [KEY_W-1:0]     write_key,
  output logic                 wren,
  input  logic                 buffer_almost_full,
  input  logic                 buffer_full,
  input  logic                 run_req,
  output logic                 start,
  output logic                 set_ready,
  output logic [GID_W-1:0]     grant_id,
  output logic [11:0]          key_count,
  output logic                 proto_err,
`ifdef KEY_LOAD_SCHED_TIMEOUT_EN
  output logic                 len_err,
  output logic                 timeout_err
`else
  output logic                 len_err
`endif
);

  logic [1:0]       r_state;
  logic [GID_W-1:0] r_gnt, r_ptr;
  logic [1:0]       r_bm;
  logic [LEN_W-1:0] r_cnt;
  logic [11:0]      r_key_count;
  key_word_t        r_wkey;
  logic             r_wren, r_start, r_proto_err, r_len_err;

  logic [NUM_REQ-1:0] w_onehot;
  logic [GID_W-1:0]   w_idx, w_ptr_nxt;
  logic               w_any, w_vld_g, w_rdy, w_acc, w_drop, w_len_hit, w_to_hit;
  logic [7:0]         w_data_g;
  logic [5:0]         w_flags_g;
  logic [1:0]         w_bm_sel;
  key_word_t          w_word;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(GID_W)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_onehot),
    .o_idx (w_idx)
  );

  assign w_any = |w_onehot;

  always_comb begin
    w_vld_g   = 1'b0;
    w_data_g  = '0;
    w_flags_g = '0;
    w_bm_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt == GID_W'(i)) begin
        w_vld_g   = req_valid[i];
        w_data_g  = req_data[8*i +: 8];
        w_flags_g = req_flags[6*i +: 6];
      end
      if (w_idx == GID_W'(i)) w_bm_sel = req_bytemode[2*i +: 2];
    end
  end

  assign w_rdy = ~buffer_almost_full & ~buffer_full;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = (r_state == ST_XFER) && (r_gnt == GID_W'(i)) && w_rdy;
  end

  assign w_word    = {w_flags_g, w_data_g};
  assign w_acc     = (r_state == ST_XFER) & w_vld_g & w_rdy;
  // Only the opening beat of a grant is checked for the first flag.
  assign w_drop    = (r_cnt == '0) & ~w_word[FIRST];
  assign w_len_hit = (r_cnt == LEN_W'(MAX_KEY_LEN - 1)) & ~w_word[LAST];
  assign w_ptr_nxt = (r_gnt == GID_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;

`ifdef KEY_LOAD_SCHED_TIMEOUT_EN
  logic [STALL_W-1:0] r_stall;
  logic               r_to_err;

  assign w_to_hit = (r_state == ST_XFER) & ~w_vld_g & (r_stall == {STALL_W{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall  <= '0;
      r_to_err <= 1'b0;
    end else begin
      if (r_state != ST_XFER || w_acc || w_to_hit) r_stall <= '0;
      else if (!w_vld_g)                           r_stall <= r_stall + 1'b1;
      if (w_to_hit) r_to_err <= 1'b1;
    end
  end

  assign timeout_err = r_to_err;
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_ptr       <= '0;
      r_bm        <= '0;
      r_cnt       <= '0;
      r_key_count <= '0;
      r_wkey      <= '0;
      r_wren      <= 1'b0;
      r_start     <= 1'b0;
      r_proto_err <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_wren  <= w_acc & ~w_drop;
      r_start <= 1'b0;
      if (w_acc) r_wkey <= w_word;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_idx;
            r_bm    <= w_bm_sel;
            r_cnt   <= '0;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_drop)    r_proto_err <= 1'b1;
            if (w_len_hit) r_len_err   <= 1'b1;
            // Length overrun releases like a last beat but never arms replay.
            if (w_word[LAST] || w_len_hit) begin
              r_key_count <= r_key_count + 1'b1;
              r_ptr       <= w_ptr_nxt;
              r_state     <= (w_word[LAST] && w_word[LASTKEY]) ? ST_ARM : ST_IDLE;
            end
          end else if (w_to_hit) begin
            r_ptr   <= w_ptr_nxt;
            r_state <= ST_IDLE;
          end
        end
        ST_ARM: begin
          if (run_req) begin
            r_start     <= 1'b1;
            r_key_count <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_id  = r_gnt;
  assign byte_mode = r_bm;
  assign write_key = r_wkey;
  assign wren      = r_wren;
  assign start     = r_start;
  assign set_ready = (r_state == ST_ARM);
  assign key_count = r_key_count;
  assign proto_err = r_proto_err;
  assign len_err   = r_len_err;

endmodule
